// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter, instruction fetch over a req/ack
// handshake, field decode for the control path, and a one-cycle execute
// strobe per instruction. The next PC is either sequential or a PC-relative
// jump chosen by NIA. The sequencer waits for data-memory completion when
// the control path flags a load or store.
module instr_sequencer #(
    parameter int unsigned         ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    // instruction memory
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    // decoded fields to the control path and datapath
    output logic [4:0]        OpFn,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [15:0]       imm,
    // feedback from the control path
    input  logic              NIA,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              dmem_done,
    // status
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [15:0]       ir_reg;
    logic [15:0]       ir_next;

    // Offset for a jump: ir[12:0] sign-extended to the PC width.
    logic [ADDR_W-1:0] jump_off;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_adv;
    logic              is_halt_op;
    logic              is_mem_op;

    genvar gi;

    // Sign-extend the 13-bit jump field bit by bit so any ADDR_W works.
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_jump_sext
            if (gi < 13) begin : g_low
                assign jump_off[gi] = ir_reg[gi];
            end else begin : g_high
                assign jump_off[gi] = ir_reg[12];
            end
        end
    endgenerate

    // Immediate output: ir[6:0] sign-extended to 16 bits.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_imm_sext
            if (gi < 7) begin : g_low
                assign imm[gi] = ir_reg[gi];
            end else begin : g_high
                assign imm[gi] = ir_reg[6];
            end
        end
    endgenerate

    // Field decode straight from the instruction register.
    assign OpFn = {ir_reg[15:13], ir_reg[1:0]};
    assign rs   = ir_reg[12:10];
    assign rt   = ir_reg[9:7];
    assign rd   = ir_reg[6:4];

    // Next-address arithmetic wraps silently at 2^ADDR_W.
    assign pc_inc = pc_reg + PC_ONE;
    assign pc_adv = NIA ? pc_inc : (pc_inc + jump_off);

    // Opcodes 110 and 111 are unsupported and stop the sequencer.
    assign is_halt_op = (ir_reg[15:14] == 2'b11);
    assign is_mem_op  = MemRead | MemWrite;

    // Strobes come only from the state register so they cannot glitch.
    assign imem_req  = (state_reg == S_FETCH);
    assign exec_en   = (state_reg == S_EXEC);
    assign halted    = (state_reg == S_HALT);
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;

    // State, PC and instruction registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // Next-state, next-PC and instruction latch decisions.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        unique case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_data;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = is_halt_op ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    state_next = S_MEMWAIT;
                end else begin
                    pc_next    = pc_adv;
                    state_next = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                if (dmem_done) begin
                    pc_next    = pc_adv;
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: walks a short program through
// sequential, jump, wrap-around, load, halt and reset-in-flight cases.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [4:0]  OpFn;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic        NIA;
    logic        MemRead;
    logic        MemWrite;
    logic        dmem_done;
    logic        exec_en;
    logic [15:0] pc;
    logic        halted;

    int n_cmp;
    int n_bad;

    instr_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .OpFn      (OpFn),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .NIA       (NIA),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .dmem_done (dmem_done),
        .exec_en   (exec_en),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report it on mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s : got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sample and drive 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one non-halting instruction starting in FETCH.
    task automatic run_instr(input logic [15:0] instr, input int ack_dly,
                             input logic nia, input logic mrd, input int mwait,
                             input logic [15:0] exp_pc, input logic [15:0] exp_next);
        logic [4:0]  prev_opfn;
        logic [15:0] exp_imm;
        exp_imm   = {{9{instr[6]}}, instr[6:0]};
        prev_opfn = OpFn;
        imem_data = instr;
        for (int c = 0; c <= ack_dly; c++) begin
            check_val("fetch_req", imem_req, 1'b1);
            check_val("fetch_addr", imem_addr, exp_pc);
            check_val("fetch_no_exec", exec_en, 1'b0);
            if (c > 0) check_val("ir_hold", OpFn, prev_opfn);
            imem_ack = (c == ack_dly);
            step();
        end
        // DECODE: feed a stray ack with junk data, which must be ignored.
        imem_data = 16'hFFFF;
        check_val("dec_req", imem_req, 1'b0);
        check_val("dec_exec", exec_en, 1'b0);
        check_val("dec_opfn", OpFn, {instr[15:13], instr[1:0]});
        check_val("dec_rs", rs, instr[12:10]);
        check_val("dec_rt", rt, instr[9:7]);
        check_val("dec_rd", rd, instr[6:4]);
        check_val("dec_imm", imm, exp_imm);
        NIA     = nia;
        MemRead = mrd;
        step();
        // EXEC: single strobe; an early dmem_done here is ignored.
        check_val("exec_en", exec_en, 1'b1);
        check_val("exec_opfn", OpFn, {instr[15:13], instr[1:0]});
        check_val("exec_pc", pc, exp_pc);
        dmem_done = mrd;
        step();
        dmem_done = 1'b0;
        if (mrd) begin
            for (int i = 1; i <= mwait; i++) begin
                check_val("mw_exec", exec_en, 1'b0);
                check_val("mw_req", imem_req, 1'b0);
                check_val("mw_pc", pc, exp_pc);
                dmem_done = (i == mwait);
                step();
            end
            dmem_done = 1'b0;
        end
        imem_ack = 1'b0;
        MemRead  = 1'b0;
        $display("instr 0x%04h at pc 0x%04h -> next pc 0x%04h", instr, exp_pc, pc);
        check_val("next_req", imem_req, 1'b1);
        check_val("next_pc", pc, exp_next);
        check_val("next_addr", imem_addr, exp_next);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        NIA       = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        dmem_done = 1'b0;
        repeat (2) step();

        // Reset values while held in reset.
        check_val("rst_pc", pc, 16'h0000);
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_exec", exec_en, 1'b0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_opfn", OpFn, 5'd0);
        check_val("rst_imm", imm, 16'h0000);
        rst = 1'b0;
        check_val("idle_req", imem_req, 1'b0);
        step();
        $display("reset released, fetch at 0x%04h", imem_addr);

        // Sequential op, zero-wait fetch.
        run_instr(16'h0002, 0, 1'b1, 1'b0, 0, 16'h0000, 16'h0001);
        // Jump +14 with a 4-cycle fetch delay: 1+1+14 = 0x10.
        run_instr(16'hA00E, 4, 1'b0, 1'b0, 0, 16'h0001, 16'h0010);
        // Jump -2 at 0x10: 0x10+1-2 = 0x0F.
        run_instr(16'hBFFE, 0, 1'b0, 1'b0, 0, 16'h0010, 16'h000F);
        // Jump -17 at 0x0F: 0x0F+1-17 = 0xFFFF.
        run_instr(16'hBFEF, 1, 1'b0, 1'b0, 0, 16'h000F, 16'hFFFF);
        // Sequential at 0xFFFF wraps to 0.
        run_instr(16'h2345, 0, 1'b1, 1'b0, 0, 16'hFFFF, 16'h0000);
        // Load with dmem_done on the 3rd MEMWAIT cycle.
        run_instr(16'h4AB5, 0, 1'b1, 1'b1, 3, 16'h0000, 16'h0001);

        // Halt opcode 110 at pc 1.
        imem_data = 16'hC000;
        imem_ack  = 1'b1;
        step();
        imem_ack = 1'b0;
        check_val("halt_dec_opfn", OpFn, 5'b11000);
        step();
        for (int i = 0; i < 4; i++) begin
            check_val("halt_flag", halted, 1'b1);
            check_val("halt_exec", exec_en, 1'b0);
            check_val("halt_req", imem_req, 1'b0);
            check_val("halt_pc", pc, 16'h0001);
            step();
        end
        $display("halted at pc 0x%04h", pc);
        #2 rst = 1'b1;
        #1;
        check_val("halt_rst_flag", halted, 1'b0);
        check_val("halt_rst_pc", pc, 16'h0000);
        check_val("halt_rst_opfn", OpFn, 5'd0);
        step();
        rst = 1'b0;
        step();
        check_val("post_halt_req", imem_req, 1'b1);
        check_val("post_halt_addr", imem_addr, 16'h0000);

        // Move to pc 1, then start a store and reset during MEMWAIT.
        run_instr(16'h0001, 0, 1'b1, 1'b0, 0, 16'h0000, 16'h0001);
        imem_data = 16'h6123;
        imem_ack  = 1'b1;
        step();
        imem_ack = 1'b0;
        MemWrite = 1'b1;
        step();
        check_val("st_exec", exec_en, 1'b1);
        step();
        step();
        check_val("st_mw_pc", pc, 16'h0001);
        #2 rst = 1'b1;
        #1;
        $display("reset in MEMWAIT, pc 0x%04h", pc);
        check_val("mw_rst_pc", pc, 16'h0000);
        check_val("mw_rst_req", imem_req, 1'b0);
        check_val("mw_rst_exec", exec_en, 1'b0);
        check_val("mw_rst_opfn", OpFn, 5'd0);
        check_val("mw_rst_imm", imm, 16'h0000);
        MemWrite  = 1'b0;
        dmem_done = 1'b1;
        step();
        rst       = 1'b0;
        dmem_done = 1'b0;
        step();
        check_val("mw_post_req", imem_req, 1'b1);
        check_val("mw_post_addr", imem_addr, 16'h0000);

        // Reset mid-fetch: request drops immediately.
        step();
        check_val("mf_req_before", imem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("mf_req_drop", imem_req, 1'b0);
        $display("reset mid-fetch, imem_req %0b", imem_req);
        step();
        rst = 1'b0;
        step();
        run_instr(16'h0403, 2, 1'b1, 1'b0, 0, 16'h0000, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch and sequencing unit that feeds the control path. Holds the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and presents `OpFn` and the register/immediate fields to the control path and datapath. It consumes `NIA`, `MemRead` and `MemWrite` back from the control path to select the next address and to stall on data-memory operations. It also issues a single-cycle execute strobe per instruction.

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  ADDR_W  fetch address (equals `pc`)
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_data`  in  16  instruction word
- `OpFn`  out  5  {instr[15:13], instr[1:0]} to control path
- `rs`, `rt`, `rd`  out  3 each  instr[12:10], instr[9:7], instr[6:4]
- `imm`  out  16  sign-extended instr[6:0]
- `NIA`  in  1  1 = sequential next address, 0 = jump
- `MemRead`, `MemWrite`  in  1 each  from control path, valid in DECODE onward
- `dmem_done`  in  1  data-memory access complete
- `exec_en`  out  1  one-cycle strobe qualifying register and memory writes
- `pc`  out  ADDR_W  current instruction address
- `halted`  out  1  sequencer stopped on an unsupported opcode

## Operation
- Instruction register `ir` (16 b) is latched on an accepted fetch. `OpFn`, `rs`, `rt`, `rd` and `imm` are combinational from `ir`.
- States:
  - IDLE: entered on reset; unconditional move to FETCH next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. When `imem_ack`=1, latch `ir`=`imem_data` and go to DECODE; otherwise hold.
  - DECODE: one cycle for the control path to settle. If `ir[15:13]` is 110 or 111, go to HALT. Otherwise go to EXEC.
  - EXEC: `exec_en`=1 for this cycle only. If `MemRead`|`MemWrite`, go to MEMWAIT. Otherwise update `pc` and go to FETCH.
  - MEMWAIT: hold until `dmem_done`=1, then update `pc` and go to FETCH. `dmem_done` outside MEMWAIT is ignored.
  - HALT: `halted`=1; exits only on `rst`.
- PC update:
  - `NIA`=1: `pc` ← `pc`+1.
  - `NIA`=0: `pc` ← `pc` + 1 + sext(`ir[12:0]`).
  - Both are computed modulo 2^ADDR_W; wrap-around is silent.
- `NIA`, `MemRead` and `MemWrite` are sampled in EXEC and MEMWAIT only.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `ir`=0 (so `OpFn`=0 and `imm`=0), `imem_req`=0, `exec_en`=0, `halted`=0.
- `imem_req` and `exec_en` are decoded from registered state and are glitch-free.
- `imem_ack` may arrive in the first FETCH cycle. Minimum fetch is therefore 1 cycle.
- Non-memory instruction with zero-wait fetch: 3 cycles (FETCH, DECODE, EXEC).
- Memory instruction: 3 cycles + N, where N ≥ 1 is the number of MEMWAIT cycles up to and including the `dmem_done` cycle.
- `pc` changes on the clock edge that leaves EXEC (non-memory) or MEMWAIT. The new `imem_addr` is valid in the following FETCH cycle.
- `exec_en` pulses exactly once per non-halting instruction. It is never asserted in FETCH, DECODE, MEMWAIT, IDLE or HALT.
- Reset mid-operation:
  - Mid-fetch: `imem_req` drops immediately (asynchronous).
  - Mid-MEMWAIT: abandons the access; no `pc` update.
- `imem_ack` outside FETCH is ignored; no `ir` update.

## Test plan
- Reset release with RESET_PC=0, `imem_ack` tied high, instr 0x0002 (opcode 000, fn 10), `NIA`=1 → `OpFn`=00010 in DECODE; `exec_en` pulse in cycle 3; `pc`=1 at next FETCH.
- `imem_ack` delayed 4 cycles → `imem_req` held high with `imem_addr` stable for 4 cycles; `ir` unchanged until the ack; DECODE entered the cycle after the ack.
- Jump at `pc`=0x0010, instr 0xBFFE (opcode 101, offset −2), `NIA`=0 → next `imem_addr`=0x000F. At `pc`=0xFFFF with `NIA`=1 → `pc` wraps to 0x0000.
- Load (opcode 010, `MemRead`=1) with `dmem_done` after 3 cycles → single `exec_en` pulse; `pc` held for 3 MEMWAIT cycles, then incremented. An early `dmem_done` asserted in EXEC has no effect.
- Instr 0xC000 (opcode 110) → HALT after DECODE; `halted`=1; no `exec_en` pulse; `imem_req`=0 indefinitely; `rst` returns to IDLE with `pc`=RESET_PC.
- `rst` asserted in MEMWAIT → all outputs take reset values in the same cycle, asynchronously; normal fetch from RESET_PC after release.
